// File: rtl/tc_sequencer.sv
// tc_sequencer: issues NUM_TC testcases and tallies results; define TC_SEQ_TIMEOUT_EN to fail testcases stuck in WAIT
module tc_sequencer #(
  parameter int NUM_TC = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       tc_valid,
  input  logic       tc_ready,
  output logic [7:0] tc_id,
  input  logic       res_valid,
  input  logic       res_pass,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic [7:0] timeout_cnt,
  output logic       all_pass
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [7:0] r_tc_id, r_pass, r_fail;
  logic w_clear, w_res, w_tout, w_last, w_expire;
`ifdef TC_SEQ_TIMEOUT_EN
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] r_wcnt;
  logic [7:0] r_tout;
  // Counter sits at zero outside WAIT, so it restarts on every WAIT entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wcnt <= '0;
    else r_wcnt <= (r_state == S_WAIT) ? r_wcnt + W'(1) : '0;
  assign w_expire = r_wcnt == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_tout <= '0;
    else if (w_clear) r_tout <= '0;
    else if (w_tout) r_tout <= r_tout + 8'd1;
  assign timeout_cnt = r_tout;
`else
  assign w_expire = 1'b0;
  assign timeout_cnt = '0;
`endif
  assign w_last = r_tc_id == 8'(NUM_TC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_clear = 1'b0;
    w_res = 1'b0;
    w_tout = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_clear = start;
        w_next = start ? S_ISSUE : r_state;
      end
      S_ISSUE: w_next = tc_ready ? S_WAIT : S_ISSUE;
      S_WAIT: begin
        w_res = res_valid;
        w_tout = !res_valid && w_expire;
        w_next = (res_valid || w_expire) ? S_NEXT : S_WAIT;
      end
      S_NEXT: w_next = w_last ? S_DONE : S_ISSUE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tc_id <= '0;
      r_pass <= '0;
      r_fail <= '0;
    end else if (w_clear) begin
      r_tc_id <= '0;
      r_pass <= '0;
      r_fail <= '0;
    end else begin
      if (w_res && res_pass) r_pass <= r_pass + 8'd1;
      if ((w_res && !res_pass) || w_tout) r_fail <= r_fail + 8'd1;
      if (r_state == S_NEXT && !w_last) r_tc_id <= r_tc_id + 8'd1;
    end
  assign tc_valid = r_state == S_ISSUE;
  assign tc_id = r_tc_id;
  assign busy = r_state == S_ISSUE || r_state == S_WAIT || r_state == S_NEXT;
  assign done = r_state == S_DONE;
  assign pass_cnt = r_pass;
  assign fail_cnt = r_fail;
  assign all_pass = done && r_fail == 8'd0;
endmodule

// File: tb/tb_tc_sequencer.sv
// tb_tc_sequencer: directed checks of tc_sequencer run flow, handshakes, reset and optional timeout
module tb_tc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic tc_ready = 1'b0;
  logic res_valid = 1'b0;
  logic res_pass = 1'b0;
  logic tc_valid, busy, done, all_pass;
  logic [7:0] tc_id, pass_cnt, fail_cnt, timeout_cnt;
  int n_chk = 0;
  int n_err = 0;
  tc_sequencer #(.NUM_TC(4), .TIMEOUT_CYCLES(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tc_valid(tc_valid), .tc_ready(tc_ready),
    .tc_id(tc_id), .res_valid(res_valid), .res_pass(res_pass), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt), .all_pass(all_pass)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  // From ISSUE with tc_ready high: handshake, report one result, land in the following state
  task automatic step_tc(input logic pass);
    tick();
    res_valid = 1'b1;
    res_pass = pass;
    tick();
    res_valid = 1'b0;
    tick();
  endtask
  task automatic chk_summary(input string tag, input int p, input int f, input int t, input logic ap);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pass"}, 32'(pass_cnt), 32'(p));
    chk({tag, "_fail"}, 32'(fail_cnt), 32'(f));
    chk({tag, "_tout"}, 32'(timeout_cnt), 32'(t));
    chk({tag, "_allpass"}, 32'(all_pass), 32'(ap));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    #1;
    chk("rst_valid", 32'(tc_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_id", 32'(tc_id), 0);
    #11 rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);
    // Back-to-back run: 3 cycles per testcase with ready and result held high
    tc_ready = 1'b1;
    res_valid = 1'b1;
    res_pass = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("r1_issue_valid", 32'(tc_valid), 1);
      chk("r1_issue_id", 32'(tc_id), 32'(i));
      chk("r1_issue_busy", 32'(busy), 1);
      tick();
      chk("r1_wait_valid", 32'(tc_valid), 0);
      tick();
      chk("r1_next_valid", 32'(tc_valid), 0);
      chk("r1_next_pass", 32'(pass_cnt), 32'(i + 1));
      tick();
    end
    res_valid = 1'b0;
    chk_summary("r1", 4, 0, 0, 1'b1);
    tick();
    chk("r1_hold_done", 32'(done), 1);
    chk("r1_hold_pass", 32'(pass_cnt), 4);
    // Restart from DONE with testcase 2 failing
    pulse_start();
    chk("r2_clear_pass", 32'(pass_cnt), 0);
    chk("r2_clear_id", 32'(tc_id), 0);
    for (int i = 0; i < 4; i++) begin
      chk("r2_id", 32'(tc_id), 32'(i));
      step_tc(i != 2);
    end
    chk_summary("r2", 3, 1, 0, 1'b0);
    // Harness stalls the handshake for 10 cycles
    tc_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(tc_valid), 1);
      chk("stall_id", 32'(tc_id), 0);
      tick();
    end
    tc_ready = 1'b1;
    tick();
    chk("wait_valid", 32'(tc_valid), 0);
    chk("wait_busy", 32'(busy), 1);
    tick();
    pulse_start();
    chk("busy_start_valid", 32'(tc_valid), 0);
    chk("busy_start_id", 32'(tc_id), 0);
    chk("busy_start_busy", 32'(busy), 1);
    res_valid = 1'b1;
    res_pass = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("late_res_pass", 32'(pass_cnt), 1);
    tick();
    chk("late_res_id", 32'(tc_id), 1);
    chk("late_res_valid", 32'(tc_valid), 1);
    step_tc(1'b1);
    tick();
    chk("pre_rst_id", 32'(tc_id), 2);
    chk("pre_rst_busy", 32'(busy), 1);
`ifndef TC_SEQ_TIMEOUT_EN
    repeat (30) tick();
    chk("hold_busy", 32'(busy), 1);
    chk("hold_valid", 32'(tc_valid), 0);
    chk("hold_id", 32'(tc_id), 2);
    chk("hold_tout", 32'(timeout_cnt), 0);
`endif
    // Asynchronous reset in the WAIT of testcase 2
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_id", 32'(tc_id), 0);
    chk("arst_pass", 32'(pass_cnt), 0);
    chk("arst_done", 32'(done), 0);
    #2 rst_n = 1'b1;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("post_rst_busy", 32'(busy), 0);
    chk("idle_res_pass", 32'(pass_cnt), 0);
    pulse_start();
    chk("r3_id", 32'(tc_id), 0);
    chk("r3_valid", 32'(tc_valid), 1);
    for (int i = 0; i < 4; i++) step_tc(1'b1);
    chk_summary("r3", 4, 0, 0, 1'b1);
`ifdef TC_SEQ_TIMEOUT_EN
    // Testcase 1 times out after 5 WAIT cycles; testcase 3 answers on the expiry cycle
    pulse_start();
    step_tc(1'b1);
    chk("to_id1", 32'(tc_id), 1);
    tick();
    repeat (4) begin
      chk("to_wait_busy", 32'(busy), 1);
      chk("to_wait_fail", 32'(fail_cnt), 0);
      tick();
    end
    chk("to_last_wait_valid", 32'(tc_valid), 0);
    tick();
    chk("to_fail", 32'(fail_cnt), 1);
    chk("to_tout", 32'(timeout_cnt), 1);
    tick();
    chk("to_id2", 32'(tc_id), 2);
    step_tc(1'b1);
    chk("to_id3", 32'(tc_id), 3);
    tick();
    repeat (4) tick();
    res_valid = 1'b1;
    res_pass = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("to_prio_pass", 32'(pass_cnt), 3);
    chk("to_prio_tout", 32'(timeout_cnt), 1);
    tick();
    chk_summary("to", 3, 1, 1, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tc_sequencer.md
TC_SEQUENCER -- requirements
Module: tc_sequencer

Interface
REQ-001 SHALL have parameter NUM_TC, default 4, number of testcases issued per run (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, WAIT-state cycle limit per testcase (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a run; sampled only in IDLE or DONE.
REQ-006 SHALL have port tc_valid  output  1  testcase index offered to harness.
REQ-007 SHALL have port tc_ready  input  1  harness accepts tc_id.
REQ-008 SHALL have port tc_id  output  8  current testcase index, 0..NUM_TC-1.
REQ-009 SHALL have port res_valid  input  1  harness reports result of current testcase.
REQ-010 SHALL have port res_pass  input  1  result qualifier: 1 pass, 0 fail.
REQ-011 SHALL have port busy  output  1  run in progress.
REQ-012 SHALL have port done  output  1  run complete; summary valid.
REQ-013 SHALL have port pass_cnt  output  8  testcases passed this run.
REQ-014 SHALL have port fail_cnt  output  8  testcases failed this run, timeouts included.
REQ-015 SHALL have port timeout_cnt  output  8  testcases failed by timeout.
REQ-016 SHALL have port all_pass  output  1  done and fail_cnt==0.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, NEXT, DONE.
REQ-018 IDLE: busy=0, done=0; start=1 -> clear all counters, tc_id=0, enter ISSUE next cycle.
REQ-019 ISSUE: tc_valid=1, busy=1; tc_id stable until handshake; tc_valid&&tc_ready -> WAIT next cycle.
REQ-020 tc_valid SHALL be 0 in every state other than ISSUE.
REQ-021 WAIT: res_valid=1 -> pass_cnt+1 if res_pass else fail_cnt+1; enter NEXT next cycle.
REQ-022 res_valid outside WAIT SHALL be ignored; no counter changes.
REQ-023 NEXT: one cycle; tc_id==NUM_TC-1 -> DONE, else tc_id+1 and ISSUE.
REQ-024 DONE: busy=0, done=1, all_pass=(fail_cnt==0); counters held; start=1 -> same as REQ-018.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 pass_cnt+fail_cnt SHALL equal number of testcases completed; counters never wrap (NUM_TC<=255).
REQ-027 Minimum per-testcase latency: tc_ready and res_valid both held high -> 3 cycles (ISSUE, WAIT, NEXT).

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, tc_valid=0, tc_id=0, busy=0, done=0, all_pass=0, all counters=0.
REQ-029 Reset mid-run SHALL abandon the run; no partial summary retained; restart requires new start after rst_n=1.

Configuration
REQ-030 Macro TC_SEQ_TIMEOUT_EN defined: WAIT cycle counter, cleared on WAIT entry; counter reaching TIMEOUT_CYCLES without res_valid -> fail_cnt+1, timeout_cnt+1, enter NEXT.
REQ-031 With TC_SEQ_TIMEOUT_EN, res_valid in the same cycle as expiry SHALL take priority; result counted normally, timeout_cnt unchanged.
REQ-032 Without TC_SEQ_TIMEOUT_EN: no timeout logic, WAIT held indefinitely, timeout_cnt tied to 0.

Verification
REQ-033 NUM_TC=4, tc_ready=1, res_valid each WAIT with res_pass=1 -> tc_id 0,1,2,3 issued in order; done=1, pass_cnt=4, fail_cnt=0, all_pass=1.
REQ-034 NUM_TC=4, res_pass=0 for tc_id=2 only -> pass_cnt=3, fail_cnt=1, all_pass=0.
REQ-035 tc_ready held low 10 cycles in ISSUE -> tc_valid=1, tc_id constant for all 10 cycles; no advance.
REQ-036 TC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=5, no res_valid for tc_id=1 -> timeout_cnt=1, fail_cnt=1, run completes with tc_id 2,3.
REQ-037 rst_n=0 during WAIT of tc_id=2 -> all outputs at reset values immediately; new start -> run from tc_id=0 with counters at 0.
REQ-038 start pulsed during busy, res_valid pulsed in IDLE -> no state or counter change.
